// File: rtl/inst_queue_if.sv
// Fetch-response handshake bundle between fetch, icache, queue and decode.
// Ports: request side (req_*), cache response (inst_*), flush, and decode side (out_*).
interface inst_queue_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  req_branch;
  logic [ADDR_WIDTH-1:0] req_predict_pc;
  logic [3:0]            req_except;
  logic                  req_ready;
  logic                  inst_data_ok;
  logic [31:0]           inst_rdata;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_predict_pc;
  logic                  out_branch;
  logic [31:0]           out_inst;
  logic [3:0]            out_except;

  modport master (
    output req_valid, req_pc, req_branch, req_predict_pc, req_except,
    output inst_data_ok, inst_rdata, flush, out_ready,
    input  req_ready, out_valid, out_pc, out_predict_pc,
    input  out_branch, out_inst, out_except
  );

  modport slave (
    input  req_valid, req_pc, req_branch, req_predict_pc, req_except,
    input  inst_data_ok, inst_rdata, flush, out_ready,
    output req_ready, out_valid, out_pc, out_predict_pc,
    output out_branch, out_inst, out_except
  );
endinterface

// File: rtl/inst_queue.sv
// In-order fetch-response queue: records requests, fills words from the icache, feeds decode.
// Ports: clk, rst (async active-high), q (inst_queue_if.slave: req_*, inst_*, flush, out_*).
module inst_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave q
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head, fill, tail, drop_cnt;
  logic [PW-1:0] count, unfilled, drop_sum;
  logic [PW:0]   occ;

  logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] ppc_mem [DEPTH];
  logic [31:0]           inst_mem[DEPTH];
  logic [3:0]            exc_mem [DEPTH];
  logic [DEPTH-1:0]      br_mem;
  logic [DEPTH-1:0]      filled;

  logic [IW-1:0] hi, fi, ti;
  logic is_exc, accept, fill_en, drop_en, deq;

  assign hi       = head[IW-1:0];
  assign fi       = fill[IW-1:0];
  assign ti       = tail[IW-1:0];
  assign count    = tail - head;
  assign unfilled = tail - fill;
  assign occ      = {1'b0, count} + {1'b0, drop_cnt};
  // Bounded by DEPTH, so it fits without the extra bit.
  assign drop_sum = drop_cnt + unfilled;

  assign is_exc = |q.req_except;

  // An exception entry carries no cache request, so it may only be
  // queued once every earlier word has returned to keep order.
  assign q.req_ready = !q.flush
                    && (occ < (PW+1)'(DEPTH))
                    && (!is_exc || unfilled == '0);

  assign accept  = q.req_valid && q.req_ready;
  assign drop_en = q.inst_data_ok && drop_cnt != '0;
  assign fill_en = q.inst_data_ok && drop_cnt == '0
                && unfilled != '0;

  assign q.out_valid = !q.flush && count != '0 && filled[hi];
  assign deq         = q.out_valid && q.out_ready;

  assign q.out_pc         = pc_mem[hi];
  assign q.out_predict_pc = ppc_mem[hi];
  assign q.out_branch     = br_mem[hi];
  assign q.out_inst       = inst_mem[hi];
  assign q.out_except     = exc_mem[hi];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      br_mem   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        ppc_mem[i]  <= '0;
        inst_mem[i] <= '0;
        exc_mem[i]  <= '0;
      end
    end else if (q.flush) begin
      head   <= tail;
      fill   <= tail;
      filled <= '0;
      // Words owed to discarded requests must be swallowed later.
      if (q.inst_data_ok && drop_sum != '0)
        drop_cnt <= drop_sum - PW'(1);
      else
        drop_cnt <= drop_sum;
    end else begin
      if (accept) begin
        pc_mem[ti]  <= q.req_pc;
        ppc_mem[ti] <= q.req_predict_pc;
        br_mem[ti]  <= q.req_branch;
        exc_mem[ti] <= q.req_except;
        tail        <= tail + PW'(1);
        if (is_exc) begin
          inst_mem[ti] <= '0;
          filled[ti]   <= 1'b1;
        end else begin
          filled[ti]   <= 1'b0;
        end
      end
      if (fill_en) begin
        inst_mem[fi] <= q.inst_rdata;
        filled[fi]   <= 1'b1;
      end
      if (fill_en || (accept && is_exc))
        fill <= fill + PW'(1);
      if (drop_en)
        drop_cnt <= drop_cnt - PW'(1);
      if (deq) begin
        head       <= head + PW'(1);
        filled[hi] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed fetch/fill/flush/exception/reset sequences.
// Stimulus pushes expected entries; a negedge monitor pops and compares on each dispatch.
module tb_inst_queue;
  logic clk;
  logic rst;

  inst_queue_if #(.ADDR_WIDTH(32)) q ();

  inst_queue #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q.slave)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        br;
    logic [31:0] ppc;
    logic [31:0] inst;
    logic [3:0]  exc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: every dispatch must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (!rst && q.out_valid && q.out_ready) begin
      a = {q.out_pc, q.out_branch, q.out_predict_pc,
           q.out_inst, q.out_except};
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_out: got %h want none", a);
      end else begin
        e = sb.pop_front();
        if (a === e) n_pass++;
        else $display("FAIL out_entry: got %h want %h", a, e);
      end
    end
  end

  task automatic setreq(input logic [31:0] pc, input logic [3:0] exc,
                        input logic [31:0] inst, input bit push);
    exp_t e;
    q.req_valid      = 1'b1;
    q.req_pc         = pc;
    q.req_branch     = pc[2];
    q.req_predict_pc = pc + 32'h40;
    q.req_except     = exc;
    if (push) begin
      e = '{pc: pc, br: pc[2], ppc: pc + 32'h40,
            inst: (exc != 4'h0) ? 32'h0 : inst, exc: exc};
      sb.push_back(e);
    end
  endtask

  task automatic data(input logic [31:0] w);
    q.inst_data_ok = 1'b1;
    q.inst_rdata   = w;
  endtask

  task automatic ng();
    @(negedge clk);
  endtask

  // Advance to just after the next rising edge and drop one-shot inputs.
  task automatic nx();
    @(posedge clk);
    #1;
    q.req_valid    = 1'b0;
    q.req_except   = 4'h0;
    q.inst_data_ok = 1'b0;
    q.flush        = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    q.req_valid      = 1'b0;
    q.req_pc         = '0;
    q.req_branch     = 1'b0;
    q.req_predict_pc = '0;
    q.req_except     = 4'h0;
    q.inst_data_ok   = 1'b0;
    q.inst_rdata     = '0;
    q.flush          = 1'b0;
    q.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(q.out_valid), 32'd0);
    chk("rst_req_ready", 32'(q.req_ready), 32'd1);
    chk("rst_out_pc", q.out_pc, 32'h0);
    chk("rst_out_inst", q.out_inst, 32'h0);
    rst = 1'b0;
    nx();

    // In-order basic
    setreq(32'h1C000000, 4'h0, 32'h02800400, 1); ng();
    chk("b_rdy0", 32'(q.req_ready), 32'd1); nx();
    setreq(32'h1C000004, 4'h0, 32'h02800800, 1); nx();
    setreq(32'h1C000008, 4'h0, 32'h02800C00, 1); nx();
    data(32'h02800400); ng();
    chk("b_lat_v0", 32'(q.out_valid), 32'd0); nx();
    data(32'h02800800); ng();
    chk("b_v0", 32'(q.out_valid), 32'd1);
    chk("b_pc0", q.out_pc, 32'h1C000000); nx();
    data(32'h02800C00); ng();
    chk("b_pc1", q.out_pc, 32'h1C000004); nx();
    ng();
    chk("b_pc2", q.out_pc, 32'h1C000008); nx();
    ng();
    chk("b_empty", 32'(q.out_valid), 32'd0); nx();

    // Full / backpressure
    q.out_ready = 1'b0;
    setreq(32'h1C000100, 4'h0, 32'h11110000, 1); nx();
    setreq(32'h1C000104, 4'h0, 32'h11110001, 1); nx();
    setreq(32'h1C000108, 4'h0, 32'h11110002, 1); nx();
    setreq(32'h1C00010C, 4'h0, 32'h11110003, 1); ng();
    chk("f_rdy3", 32'(q.req_ready), 32'd1); nx();
    setreq(32'hDEAD0000, 4'h0, 32'h0, 0);
    data(32'h11110000); ng();
    chk("f_full", 32'(q.req_ready), 32'd0); nx();
    data(32'h11110001); nx();
    data(32'h11110002); nx();
    data(32'h11110003); ng();
    chk("f_full2", 32'(q.req_ready), 32'd0); nx();
    q.out_ready = 1'b1; ng();
    chk("f_deq_v", 32'(q.out_valid), 32'd1);
    chk("f_nopass", 32'(q.req_ready), 32'd0); nx();
    q.out_ready = 1'b0; ng();
    chk("f_rdy_up", 32'(q.req_ready), 32'd1); nx();
    q.out_ready = 1'b1;
    repeat (4) nx();

    // Flush with outstanding requests
    q.out_ready = 1'b0;
    setreq(32'h1C000200, 4'h0, 32'h0, 0); nx();
    setreq(32'h1C000204, 4'h0, 32'h0, 0); nx();
    setreq(32'h1C000208, 4'h0, 32'h0, 0); nx();
    data(32'h00000011); nx();
    q.flush = 1'b1; ng();
    chk("fl_v", 32'(q.out_valid), 32'd0);
    chk("fl_rdy", 32'(q.req_ready), 32'd0); nx();
    q.out_ready = 1'b1;
    setreq(32'h1C001000, 4'h0, 32'h0000000C, 1); ng();
    chk("fl_rdy_after", 32'(q.req_ready), 32'd1); nx();
    data(32'h0000000A); nx();
    data(32'h0000000B); nx();
    data(32'h0000000C); ng();
    chk("fl_v_pre", 32'(q.out_valid), 32'd0); nx();
    ng();
    chk("fl_v_c", 32'(q.out_valid), 32'd1);
    chk("fl_inst", q.out_inst, 32'h0000000C); nx();

    // Flush coincident with data_ok
    setreq(32'h1C000300, 4'h0, 32'h0, 0); nx();
    setreq(32'h1C000304, 4'h0, 32'h0, 0); nx();
    setreq(32'h1C000308, 4'h0, 32'h0, 0); nx();
    q.flush = 1'b1;
    data(32'h00000077); nx();
    setreq(32'h1C002000, 4'h0, 32'h00000033, 1); ng();
    chk("co_rdy", 32'(q.req_ready), 32'd1); nx();
    data(32'h00000055); nx();
    data(32'h00000066); ng();
    chk("co_drop_v", 32'(q.out_valid), 32'd0); nx();
    data(32'h00000033); nx();
    ng();
    chk("co_inst", q.out_inst, 32'h00000033); nx();

    // Exception ordering
    setreq(32'h1C003000, 4'h0, 32'h12345678, 1); nx();
    setreq(32'h1C003004, 4'h1, 32'h0, 0); ng();
    chk("ex_block", 32'(q.req_ready), 32'd0); nx();
    setreq(32'h1C003004, 4'h1, 32'h0, 0);
    data(32'h12345678); ng();
    chk("ex_block2", 32'(q.req_ready), 32'd0); nx();
    setreq(32'h1C003004, 4'h1, 32'h0, 1); ng();
    chk("ex_accept", 32'(q.req_ready), 32'd1);
    chk("ex_word_v", 32'(q.out_valid), 32'd1); nx();
    ng();
    chk("ex_v", 32'(q.out_valid), 32'd1);
    chk("ex_code", 32'(q.out_except), 32'd1); nx();
    nx();

    // Async reset mid-burst
    q.out_ready = 1'b0;
    setreq(32'h1C004000, 4'h0, 32'h0, 0); nx();
    setreq(32'h1C004004, 4'h0, 32'h0, 0); nx();
    setreq(32'h1C004008, 4'h0, 32'h0, 0); nx();
    setreq(32'h1C00400C, 4'h0, 32'h0, 0); nx();
    data(32'h0BADF00D); nx();
    ng();
    chk("ar_pre_v", 32'(q.out_valid), 32'd1);
    chk("ar_pre_rdy", 32'(q.req_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("ar_v", 32'(q.out_valid), 32'd0);
    chk("ar_rdy", 32'(q.req_ready), 32'd1);
    chk("ar_pc", q.out_pc, 32'h0);
    nx();
    rst = 1'b0;
    nx();

    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d left want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
# inst_queue

Fetch-response stage between `InstFetch` and decode. Records every fetch request at issue time (pc, prediction, exception bits) in an in-order queue. Fills each entry's instruction word from the instruction-cache response stream and presents completed entries to decode in program order over a valid/ready handshake. On flush it discards queued entries and drops the cache responses still in flight, so no stale instruction reaches decode.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `ADDR_WIDTH`, default 32: pc width.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input 1: fetch issues a request this cycle (cache `addr_ok` already qualified).
- `req_pc` input ADDR_WIDTH: request pc.
- `req_branch` input 1: predicted taken.
- `req_predict_pc` input ADDR_WIDTH: predicted target.
- `req_except` input 4: {ppi, pif, tlbr, adef}; nonzero means no cache request was sent.
- `req_ready` output 1: the queue can accept a request.
- `inst_data_ok` input 1: cache returns one word, in request order.
- `inst_rdata` input 32: returned word.
- `flush` input 1: pipeline flush.
- `out_valid` output 1: the head entry is complete.
- `out_ready` input 1: decode accepts.
- `out_pc`, `out_predict_pc` output ADDR_WIDTH; `out_branch` output 1; `out_inst` output 32; `out_except` output 4.

## Operation
Pointers and counters:
- `head`, `fill` and `tail` are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
- `count = tail - head`; `unfilled = tail - fill`.
- `drop_cnt` is log2(DEPTH)+1 bits and counts cache responses still owed to flushed requests.

Request acceptance:
- `req_ready = !flush && (count + drop_cnt) < DEPTH`. If `req_except != 0`, `req_ready` additionally requires `unfilled == 0`.
- Accept when `req_valid && req_ready`: write pc, branch, predict_pc and except at `tail`, then advance `tail`.
- For an exception entry: mark it filled with `inst = 32'h0` and advance `fill` together with `tail`.

Cache responses (`inst_data_ok`), no flush:
- If `drop_cnt > 0`: decrement `drop_cnt`; the data is discarded.
- Else if `unfilled > 0`: write `inst_rdata` to entry `fill`, mark it filled, and advance `fill`.
- Else: the response is spurious and is ignored; no state changes.

Output:
- `out_valid = !flush && count > 0 && filled[head]`.
- Outputs show the fields of entry `head` (registered array read).
- When `out_valid && out_ready`: advance `head` and clear `filled[head]`.

Flush (takes priority over everything else):
- `head`, `fill` and `tail` are set equal to `tail`, and all filled bits are cleared.
- `drop_cnt <= drop_cnt + unfilled - (inst_data_ok ? 1 : 0)`, saturating at 0.
- No request is accepted and nothing is dispatched in the flush cycle.

## Timing
- Reset values: `out_valid = 0`, `req_ready = 1`, `out_*` data = 0, all pointers 0, `drop_cnt = 0`, all filled bits 0.
- Latency:
  - A cache word with `data_ok` in cycle N appears with `out_valid = 1` in N+1 at the earliest.
  - An exception entry accepted in N appears in N+1.
- Entries are dispatched strictly in acceptance order, including exception entries.
- Full: when `count + drop_cnt == DEPTH`, `req_ready = 0`. A dispatch in cycle N raises `req_ready` in N+1. There is no same-cycle pass-through.
- Simultaneous events:
  - Accept, fill and dispatch can all happen in the same cycle.
  - A fill and a dispatch of the same entry never happen in the same cycle.
- Reset asserted mid-operation clears all state immediately. Cache responses still in flight after reset are the cache's responsibility (the cache is reset too).

## Test plan
- **In-order basic:** accept pc 0x1C000000, 0x1C000004 and 0x1C000008; `data_ok` with 0x02800400, 0x02800800 and 0x02800C00 on consecutive cycles; `out_ready = 1` -> three outputs in order, each one cycle after its data, with matching pc.
- **Full/backpressure:** DEPTH=4, `out_ready = 0`; four requests accepted and filled -> `req_ready = 0`; assert `out_ready` for one cycle -> `req_ready = 1` the next cycle.
- **Flush with outstanding requests:** three requests accepted, one filled, flush -> `out_valid = 0`, `drop_cnt = 2`; request pc 0x1C001000 accepted; three `data_ok` (0xA, 0xB, 0xC) -> only 0xC is output, with pc 0x1C001000.
- **Flush coincident with `data_ok`:** three requests accepted and unfilled, flush and `data_ok` in the same cycle -> `drop_cnt = 2`; the next two responses are discarded.
- **Exception ordering:** one request unfilled, exception request with except 4'b0001 -> `req_ready = 0` until the data returns, then it is accepted; output order is the cache word, then inst 0x0 with except 4'b0001.
- **Async reset:** assert `rst` mid-burst between clock edges -> `out_valid = 0` and `req_ready = 1` immediately, without waiting for a clock edge.
